// File: rtl/program_loader.sv
// Serial program loader: assembles bytes MSB-first into instruction words and
// writes them sequentially into program memory until HALT_WORD is stored.
module program_loader #(
  parameter int                 NB_DATA        = 32,
  parameter int                 NB_BYTE        = 8,
  parameter int                 NB_ADDRESS     = 8,
  parameter int                 RAM_DEPTH      = 256,
  parameter logic [NB_DATA-1:0] HALT_WORD      = 32'hFFFFFFFF,
  parameter int                 TIMEOUT_CYCLES = 1000
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_load_start,
  input  logic [NB_BYTE-1:0]    i_rx_data,
  input  logic                  i_rx_valid,
  output logic [NB_DATA-1:0]    o_write_data,
  output logic [NB_ADDRESS-1:0] o_write_address,
  output logic                  o_write_enable,
  output logic                  o_busy,
  output logic                  o_load_done,
  output logic [1:0]            o_error,
  output logic [NB_ADDRESS:0]   o_word_count
);

  localparam int BYTES = NB_DATA / NB_BYTE;
  localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CNT_W = NB_ADDRESS + 1;

  localparam logic [IDX_W-1:0]      LAST_IDX  = IDX_W'(BYTES - 1);
  localparam logic [NB_ADDRESS-1:0] LAST_ADDR = NB_ADDRESS'(RAM_DEPTH - 1);
  localparam logic [CNT_W-1:0]      CNT_MAX   = CNT_W'(RAM_DEPTH);
  localparam logic [TO_W-1:0]       TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_RECEIVE, S_WRITE, S_DONE, S_ERROR
  } state_e;

  state_e                state_q, state_d;
  logic [NB_DATA-1:0]    word_q, word_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [NB_ADDRESS-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [TO_W-1:0]       to_q, to_d;
  logic [1:0]            err_q, err_d;
  logic [NB_DATA-1:0]    wdata_q, wdata_d;
  logic [NB_ADDRESS-1:0] waddr_q, waddr_d;
  logic [NB_DATA-1:0]    shifted;

  assign shifted = {word_q[NB_DATA-NB_BYTE-1:0], i_rx_data};

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      word_q  <= '0;
      idx_q   <= '0;
      addr_q  <= '0;
      count_q <= '0;
      to_q    <= '0;
      err_q   <= '0;
      wdata_q <= '0;
      waddr_q <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      to_q    <= to_d;
      err_q   <= err_d;
      wdata_q <= wdata_d;
      waddr_q <= waddr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    count_d = count_q;
    to_d    = to_q;
    err_d   = err_q;
    wdata_d = wdata_q;
    waddr_d = waddr_q;
    unique case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        // A byte arriving with the start pulse is dropped on purpose.
        if (i_load_start) begin
          state_d = S_RECEIVE;
          word_d  = '0;
          idx_d   = '0;
          addr_d  = '0;
          count_d = '0;
          to_d    = '0;
          err_d   = 2'b00;
        end
      end
      S_RECEIVE: begin
        if (i_rx_valid) begin
          word_d = shifted;
          to_d   = '0;
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            wdata_d = shifted;
            waddr_d = addr_q;
            state_d = S_WRITE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else if (idx_q != '0) begin
          if (to_q == TO_LAST) begin
            state_d = S_ERROR;
            err_d   = 2'b10;
            idx_d   = '0;
            to_d    = '0;
          end else begin
            to_d = to_q + 1'b1;
          end
        end
      end
      S_WRITE: begin
        // Address saturates so an overflowing load never wraps back to 0.
        if (addr_q != LAST_ADDR) addr_d = addr_q + 1'b1;
        if (count_q != CNT_MAX) count_d = count_q + 1'b1;
        to_d  = '0;
        idx_d = '0;
        if (wdata_q == HALT_WORD) begin
          state_d = S_DONE;
        end else if (addr_q == LAST_ADDR) begin
          state_d = S_ERROR;
          err_d   = 2'b01;
        end else begin
          state_d = S_RECEIVE;
          if (i_rx_valid) begin
            word_d = shifted;
            idx_d  = IDX_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    o_write_enable  = (state_q == S_WRITE);
    o_busy          = (state_q == S_RECEIVE) || (state_q == S_WRITE);
    o_load_done     = (state_q == S_DONE);
    o_error         = (state_q == S_ERROR) ? err_q : 2'b00;
    o_write_data    = wdata_q;
    o_write_address = waddr_q;
    o_word_count    = count_q;
  end

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: expected writes are queued by the
// stimulus and popped by a monitor on every write strobe.
module tb_program_loader;

  localparam int NB_DATA = 32;
  localparam int NB_BYTE = 8;
  localparam int NB_ADDRESS = 8;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  load_start;
  logic [NB_BYTE-1:0]    rx_data;
  logic                  rx_valid;
  logic [NB_DATA-1:0]    write_data;
  logic [NB_ADDRESS-1:0] write_address;
  logic                  write_enable;
  logic                  busy;
  logic                  load_done;
  logic [1:0]            error;
  logic [NB_ADDRESS:0]   word_count;

  int tests  = 0;
  int failed = 0;
  logic [NB_ADDRESS+NB_DATA-1:0] exp_q[$];

  program_loader dut (
    .i_clock        (clk),
    .i_reset        (rst),
    .i_load_start   (load_start),
    .i_rx_data      (rx_data),
    .i_rx_valid     (rx_valid),
    .o_write_data   (write_data),
    .o_write_address(write_address),
    .o_write_enable (write_enable),
    .o_busy         (busy),
    .o_load_done    (load_done),
    .o_error        (error),
    .o_word_count   (word_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic do_start();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8]);
  endtask

  task automatic expect_write(input logic [7:0] a, input logic [31:0] d);
    exp_q.push_back({a, d});
  endtask

  task automatic check_outputs(input string name, input logic b, input logic d,
                               input logic [1:0] e, input logic [8:0] c);
    check({name, "_busy"}, 64'(busy), 64'(b));
    check({name, "_done"}, 64'(load_done), 64'(d));
    check({name, "_err"}, 64'(error), 64'(e));
    check({name, "_count"}, 64'(word_count), 64'(c));
  endtask

  // Monitor: every strobe must match the oldest queued write.
  initial begin
    logic [NB_ADDRESS+NB_DATA-1:0] exp;
    forever begin
      @(negedge clk);
      if (write_enable === 1'b1) begin
        if (exp_q.size() == 0) begin
          tests++;
          failed++;
          $display("FAIL unexpected_write: got @%0h=%0h expected none", write_address, write_data);
        end else begin
          exp = exp_q.pop_front();
          check("write", {24'd0, write_address, write_data}, {24'd0, exp});
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] w;
    rst = 1'b0; load_start = 1'b0; rx_data = '0; rx_valid = 1'b0;
    do_reset();
    check_outputs("reset", 1'b0, 1'b0, 2'b00, 9'd0);
    check("reset_we", 64'(write_enable), 64'd0);
    check("reset_wdata", 64'(write_data), 64'd0);
    check("reset_waddr", 64'(write_address), 64'd0);

    // Basic load ending in HALT.
    do_start();
    check_outputs("start", 1'b1, 1'b0, 2'b00, 9'd0);
    expect_write(8'd0, 32'h20010005);
    expect_write(8'd1, 32'hFFFFFFFF);
    send_word(32'h20010005);
    send_word(32'hFFFFFFFF);
    tick();
    check_outputs("halt", 1'b0, 1'b1, 2'b00, 9'd2);

    // Bytes in IDLE and with the start pulse are discarded.
    do_reset();
    send_byte(8'hAA);
    check_outputs("idle_byte", 1'b0, 1'b0, 2'b00, 9'd0);
    rx_data = 8'hBB; rx_valid = 1'b1; load_start = 1'b1;
    tick();
    rx_valid = 1'b0; load_start = 1'b0;
    expect_write(8'd0, 32'h00000001);
    send_word(32'h00000001);
    tick();
    check_outputs("discard", 1'b1, 1'b0, 2'b00, 9'd1);
    check("hold_wdata", 64'(write_data), 64'h00000001);

    // Byte during WRITE becomes byte 0 of the next word.
    do_reset();
    do_start();
    expect_write(8'd0, 32'h11223344);
    expect_write(8'd1, 32'hAABBCCDD);
    send_word(32'h11223344);
    send_word(32'hAABBCCDD);
    tick();
    check_outputs("back2back", 1'b1, 1'b0, 2'b00, 9'd2);
    for (int i = 0; i < 1100; i++) tick();
    check_outputs("idle_pause", 1'b1, 1'b0, 2'b00, 9'd2);

    // Timeout inside a partial word.
    do_reset();
    do_start();
    send_byte(8'h12);
    send_byte(8'h34);
    for (int i = 0; i < 999; i++) tick();
    check_outputs("to_edge", 1'b1, 1'b0, 2'b00, 9'd0);
    tick();
    check_outputs("timeout", 1'b0, 1'b0, 2'b10, 9'd0);
    do_start();
    check_outputs("restart", 1'b1, 1'b0, 2'b00, 9'd0);

    // Reset mid-word aborts the load.
    do_reset();
    do_start();
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
    do_reset();
    send_byte(8'h04);
    check_outputs("mid_reset", 1'b0, 1'b0, 2'b00, 9'd0);
    check("mid_reset_we", 64'(write_enable), 64'd0);
    check("mid_reset_wdata", 64'(write_data), 64'd0);
    tick();

    // Overflow: 256 non-halt words fill the memory.
    do_start();
    for (int i = 0; i < 256; i++) begin
      w = {8'(i), 8'hA5, 8'h5A, ~8'(i)};
      expect_write(8'(i), w);
      send_word(w);
    end
    tick();
    check_outputs("overflow", 1'b0, 1'b0, 2'b01, 9'd256);
    send_word(32'h01020304);
    tick();
    check("overflow_waddr", 64'(write_address), 64'd255);
    check_outputs("overflow_hold", 1'b0, 1'b0, 2'b01, 9'd256);

    tick(); tick();
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
